// File: rtl/dmem_pkg.sv
// Shared encodings and the request legality check for the data-memory port master.
package dmem_pkg;

  localparam int unsigned DMEM_BYTES_DEFAULT = 128;

  typedef enum logic [1:0] {
    OP_LOAD  = 2'b00,
    OP_STORE = 2'b01,
    OP_SWAP  = 2'b10,
    OP_RSVD  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WR,
    SWP_WR,
    RESP
  } state_e;

  // The address is widened to 64 bits so one function serves any AW up to 64.
  function automatic logic req_bad(input logic [1:0]  op,
                                   input logic [63:0] addr,
                                   input logic [63:0] mem_bytes);
    return (op == OP_RSVD) || (addr[1:0] != 2'b00) || (addr > (mem_bytes - 64'd4));
  endfunction

endpackage

// File: rtl/dmem_port_master.sv
// Initiator for one Data_Memory port: load/store/atomic-swap requests in,
// memory port sequencing, read data and status out over valid/ready.
//
// state  | meaning
// IDLE   | ready for a request
// RD     | memory read, data sampled at the closing edge
// WR     | store write
// SWP_WR | second half of a swap, immediately after its read
// RESP   | response held until the consumer takes it
module dmem_port_master
  import dmem_pkg::*;
#(
  parameter int unsigned MEM_BYTES = DMEM_BYTES_DEFAULT,
  parameter int unsigned AW        = 32,
  parameter int unsigned DW        = 32
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          req_valid_i,
  output logic          req_ready_o,
  input  logic [1:0]    req_op_i,
  input  logic [AW-1:0] req_addr_i,
  input  logic [DW-1:0] req_wdata_i,
  output logic          rsp_valid_o,
  input  logic          rsp_ready_i,
  output logic [DW-1:0] rsp_rdata_o,
  output logic          rsp_err_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_data_o,
  output logic          mem_read_o,
  output logic          mem_write_o,
  input  logic [DW-1:0] mem_data_i
);

  state_e        state_q, state_d;
  logic          swap_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] rdata_q;
  logic          err_q;
  logic          accept;
  logic          bad;

  assign accept = req_valid_i && (state_q == IDLE);
  assign bad    = req_bad(req_op_i, 64'(req_addr_i), 64'(MEM_BYTES));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          if (bad) begin
            state_d = RESP;
          end else begin
            case (op_e'(req_op_i))
              OP_LOAD:  state_d = RD;
              OP_STORE: state_d = WR;
              OP_SWAP:  state_d = RD;
              default:  state_d = RESP;
            endcase
          end
        end
      end
      RD:      state_d = swap_q ? SWP_WR : RESP;
      WR:      state_d = RESP;
      SWP_WR:  state_d = RESP;
      RESP:    if (rsp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      swap_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        swap_q  <= (req_op_i == OP_SWAP);
        rdata_q <= '0;
        err_q   <= bad;
        // Port address/data only move for real accesses so they hold across errors.
        if (!bad) begin
          addr_q <= req_addr_i;
          if (req_op_i != OP_LOAD) wdata_q <= req_wdata_i;
        end
      end
      if (state_q == RD) rdata_q <= mem_data_i;
    end
  end

  // Strobes decode straight from the state flop, so reset drops them asynchronously.
  assign req_ready_o = (state_q == IDLE);
  assign rsp_valid_o = (state_q == RESP);
  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;
  assign mem_read_o  = (state_q == RD);
  assign mem_write_o = (state_q == WR) || (state_q == SWP_WR);
  assign mem_addr_o  = addr_q;
  assign mem_data_o  = wdata_q;

endmodule
